pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the rv32i cores; successor to the single-cycle word-address PC. It produces a byte-addressed fetch PC with a valid/ready handshake to instruction memory. It adds stall, prioritised trap/redirect, misaligned-target detection and a halt/resume mode, all on a single rising clock edge. It sits at the head of the fetch stage, driven by the branch unit (redirect) and the trap/CSR logic (trap, halt).

## Interface
- XLEN, 32, address width in bits
- RESET_ADDR, 32'h0000_0000, PC value loaded by reset
- ALIGN_BITS, 2, log2 of instruction alignment in bytes; sequential step is 2**ALIGN_BITS
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline hold; blocks sequential advance only
- redirect  in  1  branch/jump taken this cycle
- redirect_addr  in  XLEN  branch/jump target (byte address)
- trap  in  1  exception/interrupt entry
- trap_addr  in  XLEN  trap vector; low ALIGN_BITS ignored (forced 0)
- halt  in  1  request to stop fetching
- resume  in  1  leave HALT
- fetch_ready  in  1  instruction memory accepts pc
- fetch_valid  out  1  pc is a valid fetch request
- pc  out  XLEN  current fetch address, registered
- pc_plus  out  XLEN  pc + 2**ALIGN_BITS, combinational from pc (link value)
- misalign  out  1  one-cycle pulse: redirect target misaligned
- misalign_addr  out  XLEN  offending redirect_addr, held until next misalign

## Operation
- States: BOOT, RUN, HALT.
- Reset (async): state=BOOT, pc=RESET_ADDR, fetch_valid=0, misalign=0, misalign_addr=0.
- BOOT: unconditionally to RUN next edge; inputs ignored; fetch_valid becomes 1 on entering RUN.
- advance = fetch_valid & fetch_ready & ~stall.
- Next-pc priority in RUN:
  - 1 trap: pc=trap_addr & ~mask.
  - 2 redirect with aligned target: pc=redirect_addr.
  - 3 redirect with misaligned target (redirect_addr[ALIGN_BITS-1:0]!=0): pc=trap_addr & ~mask; misalign=1 next cycle; misalign_addr=redirect_addr.
  - 4 advance: pc=pc+2**ALIGN_BITS.
  - 5 hold.
- Trap and redirect override stall and fetch_ready (flush). This is the only case in which pc changes while fetch_valid=1 & fetch_ready=0.
- RUN→HALT when halt=1 and neither trap nor redirect. pc holds; fetch_valid=0 from the next cycle.
- HALT:
  - trap → pc=trap vector, RUN.
  - else resume → RUN, pc unchanged.
  - redirect → pc updated (same alignment rule), stay HALT.
  - halt and stall are ignored.
- Arithmetic: modulo 2**XLEN. pc=all-ones-aligned plus step wraps to 0, no flag.

## Timing
- Every output except pc_plus is registered; redirect/trap to new pc latency is one cycle.
- fetch_valid is 1 in every RUN cycle, including the cycle after a redirect or trap.
- misalign is high exactly one cycle, coincident with pc=trap vector.
- halt, resume and trap in the same HALT cycle: trap wins.
- halt and trap in the same RUN cycle: trap wins; stays RUN.
- Reset asserted mid-operation: immediate return to BOOT values, regardless of clock.

## Structure
- Package pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the step constant 2**ALIGN_BITS;
  - the alignment mask function.
- One sub-module is natural: pc_next_sel, the combinational priority mux. It outputs next_pc, take_misalign and next_state. The top holds state, pc and misalign registers.

## Test plan
- Reset with RESET_ADDR=32'h100, fetch_ready=1: pc=0x100, fetch_valid=0 for 1 cycle. Then fetch_valid=1 and pc steps 0x100, 0x104, 0x108.
- fetch_ready=0 for 3 cycles at pc=0x200, then stall=1 for 2 cycles: pc holds 0x200 for all 5 cycles, then steps to 0x204.
- Same cycle: redirect_addr=0x400 with trap=1, trap_addr=0x83 → pc=0x80, misalign=0. Next, redirect_addr=0x402 alone → pc=0x80, misalign pulse, misalign_addr=0x402.
- pc=0xFFFF_FFFC, advance → pc=0x0000_0000, fetch_valid stays 1.
- halt at pc=0x300 → fetch_valid=0, pc=0x300 held 4 cycles. redirect to 0x500 while halted → pc=0x500, still halted. resume → fetch_valid=1 at 0x500.
- Assert rst asynchronously mid-stream at pc=0x1234 → pc=RESET_ADDR and fetch_valid=0 before the next clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch program-counter generator.
package pc_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   localparam int DEFAULT_ALIGN_BITS = 2;
   localparam int DEFAULT_PC_STEP    = 1 << DEFAULT_ALIGN_BITS;

   // Sequential fetch step in bytes for a given alignment.
   function automatic logic [63:0] pc_step(input int align_bits);
      return 64'd1 << align_bits;
   endfunction

   // Low-bit mask covering the sub-instruction byte offset.
   function automatic logic [63:0] align_mask(input int align_bits);
      return (64'd1 << align_bits) - 64'd1;
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority mux choosing the next fetch PC and controller state.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ALIGN_BITS = 2
) (
   input  pc_state_t         i_state,
   input  logic [XLEN-1:0]   i_pc,
   input  logic              i_fetch_valid,
   input  logic              i_fetch_ready,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [XLEN-1:0]   i_redirect_addr,
   input  logic              i_trap,
   input  logic [XLEN-1:0]   i_trap_addr,
   input  logic              i_halt,
   input  logic              i_resume,
   output logic [XLEN-1:0]   o_next_pc,
   output logic              o_take_misalign,
   output pc_state_t         o_next_state
);

   localparam logic [XLEN-1:0] STEP = XLEN'(pc_step(ALIGN_BITS));
   localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(ALIGN_BITS));

   logic [XLEN-1:0] w_trap_vec;
   logic [XLEN-1:0] w_redirect_pc;
   logic            w_misaligned;
   logic            w_advance;

   assign w_trap_vec    = i_trap_addr & ~MASK;
   assign w_misaligned  = (i_redirect_addr & MASK) != '0;
   // A misaligned branch target vectors straight to the trap handler.
   assign w_redirect_pc = w_misaligned ? w_trap_vec : i_redirect_addr;
   assign w_advance     = i_fetch_valid & i_fetch_ready & ~i_stall;

   always_comb begin
      o_next_pc       = i_pc;
      o_next_state    = i_state;
      o_take_misalign = 1'b0;
      case (i_state)
         BOOT: begin
            o_next_state = RUN;
         end
         RUN: begin
            if (i_trap) begin
               o_next_pc = w_trap_vec;
            end else if (i_redirect) begin
               o_next_pc       = w_redirect_pc;
               o_take_misalign = w_misaligned;
            end else if (i_halt) begin
               o_next_state = HALT;
            end else if (w_advance) begin
               o_next_pc = i_pc + STEP;
            end
         end
         HALT: begin
            if (i_trap) begin
               o_next_pc    = w_trap_vec;
               o_next_state = RUN;
            end else if (i_resume) begin
               o_next_state = RUN;
            end else if (i_redirect) begin
               o_next_pc       = w_redirect_pc;
               o_take_misalign = w_misaligned;
            end
         end
         default: begin
            o_next_state = BOOT;
         end
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: state, PC and misalign registers around pc_next_sel.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_ADDR = '0,
   parameter int              ALIGN_BITS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_addr,
   input  logic              trap,
   input  logic [XLEN-1:0]   trap_addr,
   input  logic              halt,
   input  logic              resume,
   input  logic              fetch_ready,
   output logic              fetch_valid,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   pc_plus,
   output logic              misalign,
   output logic [XLEN-1:0]   misalign_addr
);

   localparam logic [XLEN-1:0] STEP = XLEN'(pc_step(ALIGN_BITS));

   pc_state_t       r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_fetch_valid;
   logic            r_misalign;
   logic [XLEN-1:0] r_misalign_addr;

   pc_state_t       w_next_state;
   logic [XLEN-1:0] w_next_pc;
   logic            w_take_misalign;

   pc_next_sel #(
      .XLEN       (XLEN),
      .ALIGN_BITS (ALIGN_BITS)
   ) u_next_sel (
      .i_state         (r_state),
      .i_pc            (r_pc),
      .i_fetch_valid   (r_fetch_valid),
      .i_fetch_ready   (fetch_ready),
      .i_stall         (stall),
      .i_redirect      (redirect),
      .i_redirect_addr (redirect_addr),
      .i_trap          (trap),
      .i_trap_addr     (trap_addr),
      .i_halt          (halt),
      .i_resume        (resume),
      .o_next_pc       (w_next_pc),
      .o_take_misalign (w_take_misalign),
      .o_next_state    (w_next_state)
   );

   // fetch_valid is a registered decode of the RUN state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= BOOT;
         r_pc            <= RESET_ADDR;
         r_fetch_valid   <= 1'b0;
         r_misalign      <= 1'b0;
         r_misalign_addr <= '0;
      end else begin
         r_state       <= w_next_state;
         r_pc          <= w_next_pc;
         r_fetch_valid <= (w_next_state == RUN);
         r_misalign    <= w_take_misalign;
         if (w_take_misalign) begin
            r_misalign_addr <= redirect_addr;
         end
      end
   end

   assign fetch_valid   = r_fetch_valid;
   assign pc            = r_pc;
   assign pc_plus       = r_pc + STEP;
   assign misalign      = r_misalign;
   assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

   localparam int          XLEN       = 32;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        trap;
   logic [31:0] trap_addr;
   logic        halt;
   logic        resume;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus;
   logic        misalign;
   logic [31:0] misalign_addr;

   int n_checks = 0;
   int n_errors = 0;

   pc_gen #(
      .XLEN       (XLEN),
      .RESET_ADDR (RESET_ADDR),
      .ALIGN_BITS (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .trap          (trap),
      .trap_addr     (trap_addr),
      .halt          (halt),
      .resume        (resume),
      .fetch_ready   (fetch_ready),
      .fetch_valid   (fetch_valid),
      .pc            (pc),
      .pc_plus       (pc_plus),
      .misalign      (misalign),
      .misalign_addr (misalign_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = '0;
      trap = 1'b0; trap_addr = '0; halt = 1'b0; resume = 1'b0; fetch_ready = 1'b1;

      #12;
      check("rst_pc",    pc, 32'h100);
      check("rst_fv",    {31'd0, fetch_valid}, 32'd0);
      check("rst_mis",   {31'd0, misalign}, 32'd0);
      check("rst_maddr", misalign_addr, 32'd0);
      rst = 1'b0;

      // BOOT -> RUN, then sequential advance
      tick();
      check("boot_fv", {31'd0, fetch_valid}, 32'd1);
      check("boot_pc", pc, 32'h100);
      tick();
      check("seq_104", pc, 32'h104);
      tick();
      check("seq_108", pc, 32'h108);
      check("pc_plus", pc_plus, 32'h10C);

      // fetch_ready low then stall: pc holds at 0x200
      redirect = 1'b1; redirect_addr = 32'h200;
      tick();
      check("redir_200", pc, 32'h200);
      redirect = 1'b0; fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("nrdy_hold", pc, 32'h200);
      end
      fetch_ready = 1'b1; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stall_hold", pc, 32'h200);
      end
      stall = 1'b0;
      tick();
      check("step_204", pc, 32'h204);

      // trap beats redirect; then misaligned redirect
      redirect = 1'b1; redirect_addr = 32'h400; trap = 1'b1; trap_addr = 32'h83;
      tick();
      check("trap_pc",  pc, 32'h80);
      check("trap_mis", {31'd0, misalign}, 32'd0);
      trap = 1'b0; redirect_addr = 32'h402;
      tick();
      check("mis_pc",    pc, 32'h80);
      check("mis_pulse", {31'd0, misalign}, 32'd1);
      check("mis_addr",  misalign_addr, 32'h402);
      redirect = 1'b0;
      tick();
      check("mis_clear", {31'd0, misalign}, 32'd0);
      check("mis_held",  misalign_addr, 32'h402);
      check("after_mis", pc, 32'h84);

      // wrap-around
      redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
      tick();
      check("top_pc", pc, 32'hFFFF_FFFC);
      check("top_plus", pc_plus, 32'h0);
      redirect = 1'b0;
      tick();
      check("wrap_pc", pc, 32'h0);
      check("wrap_fv", {31'd0, fetch_valid}, 32'd1);

      // halt, redirect while halted, resume
      redirect = 1'b1; redirect_addr = 32'h300;
      tick();
      redirect = 1'b0; halt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("halt_pc", pc, 32'h300);
         check("halt_fv", {31'd0, fetch_valid}, 32'd0);
      end
      halt = 1'b0; redirect = 1'b1; redirect_addr = 32'h500;
      tick();
      check("hredir_pc", pc, 32'h500);
      check("hredir_fv", {31'd0, fetch_valid}, 32'd0);
      redirect = 1'b0; resume = 1'b1;
      tick();
      check("resume_pc", pc, 32'h500);
      check("resume_fv", {31'd0, fetch_valid}, 32'd1);
      resume = 1'b0;
      tick();
      check("resume_step", pc, 32'h504);

      // halt and trap together in RUN: trap wins, stays RUN
      halt = 1'b1; trap = 1'b1; trap_addr = 32'h1000;
      tick();
      check("ht_pc", pc, 32'h1000);
      check("ht_fv", {31'd0, fetch_valid}, 32'd1);
      halt = 1'b0; trap = 1'b0;
      tick();
      check("ht_step", pc, 32'h1004);

      // asynchronous reset mid-stream
      redirect = 1'b1; redirect_addr = 32'h1234;
      tick();
      redirect = 1'b0; fetch_ready = 1'b0;
      check("pre_rst_pc", pc, 32'h1234);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pc", pc, RESET_ADDR);
      check("arst_fv", {31'd0, fetch_valid}, 32'd0);
      #1;
      rst = 1'b0; fetch_ready = 1'b1;
      tick();
      check("reboot_fv", {31'd0, fetch_valid}, 32'd1);
      check("reboot_pc", pc, RESET_ADDR);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
